// File: rtl/axo_bram_pkg.sv
// Shared types and constants for the axo_bram request/response port.
// The response entry is sized for the widest supported word; narrower instances zero-extend.
package axo_bram_pkg;

  localparam int unsigned fifo_depth = 2;
  localparam int unsigned fifo_cnt_w = $clog2(fifo_depth + 1);
  localparam int unsigned fifo_ptr_w = $clog2(fifo_depth);

  // Upper bound on dbytes*blen; unused high bits are constant zero and trim away.
  localparam int unsigned max_dbits = 256;

  typedef struct packed {
    logic [max_dbits-1:0] rdata;
    logic                 err;
  } rsp_entry_t;

endpackage

// File: rtl/axo_bram_rsp_fifo.sv
// Two-entry response FIFO with simultaneous push/pop support, including when full.
module axo_bram_rsp_fifo
  import axo_bram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  rsp_entry_t            push_data,
  input  logic                  pop,
  output rsp_entry_t            head,
  output logic [fifo_cnt_w-1:0] count
);

  rsp_entry_t            mem_reg [fifo_depth];
  logic [fifo_ptr_w-1:0] wr_ptr_reg;
  logic [fifo_ptr_w-1:0] rd_ptr_reg;
  logic [fifo_cnt_w-1:0] count_reg;

  // Payload storage needs no reset: an entry is only observed once counted.
  for (genvar gi = 0; gi < fifo_depth; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == fifo_ptr_w'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/axo_bram_port.sv
// Valid/ready request port onto a single-port read-first BRAM with in-order buffered responses.
// Optional AXO_BRAM_RANGE_CHECK_EN: reject misaligned / out-of-range addresses with rsp_err.
module axo_bram_port
  import axo_bram_pkg::*;
#(
  parameter int unsigned abits  = 8,
  parameter int unsigned dbytes = 4,
  parameter int unsigned blen   = 8,
  parameter int unsigned pabits = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [pabits-1:0] req_addr,
  input  logic [dbytes-1:0] req_we,
  input  logic [dbytes*blen-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [dbytes*blen-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [dbytes-1:0] ram_we,
  output logic [abits-1:0]  ram_addr,
  output logic [dbytes*blen-1:0] ram_wdata,
  input  logic [dbytes*blen-1:0] ram_rdata
);

  localparam int unsigned dbits = dbytes * blen;
  localparam int unsigned lsb   = $clog2(dbytes);

  logic                  accept;
  logic                  pop;
  logic                  req_err;
  logic                  inflight_reg;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [fifo_cnt_w-1:0] fifo_cnt;
  rsp_entry_t            fifo_head;
  rsp_entry_t            in_entry;
  rsp_entry_t            head;
  logic                  unused_bits;

  assign accept = req_valid && req_ready;

`ifdef AXO_BRAM_RANGE_CHECK_EN
  localparam logic [pabits-1:0] hi_mask = {pabits{1'b1}} << (abits + lsb);
  localparam logic [pabits-1:0] lo_mask = ~({pabits{1'b1}} << lsb);

  logic inflight_err_reg;

  assign req_err = (|(req_addr & hi_mask)) || (|(req_addr & lo_mask));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_err_reg <= 1'b0;
    end else begin
      inflight_err_reg <= accept && req_err;
    end
  end

  always_comb begin
    in_entry = '0;
    if (inflight_err_reg) begin
      in_entry.err = 1'b1;
    end else begin
      in_entry.rdata = max_dbits'(ram_rdata);
    end
  end
`else
  assign req_err = 1'b0;

  always_comb begin
    in_entry       = '0;
    in_entry.rdata = max_dbits'(ram_rdata);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= accept;
    end
  end

  assign fifo_empty = (fifo_cnt == '0);

  // An empty FIFO is bypassed so the RAM word is visible the cycle it returns.
  assign head      = fifo_empty ? in_entry : fifo_head;
  assign rsp_valid = rst_n && (!fifo_empty || inflight_reg);
  assign pop       = rsp_valid && rsp_ready;
  assign fifo_push = inflight_reg && !(fifo_empty && pop);
  assign fifo_pop  = pop && !fifo_empty;

  // Credit check counts the response already reading out of the RAM.
  assign req_ready = rst_n &&
                     ((({1'b0, fifo_cnt} + {{fifo_cnt_w{1'b0}}, inflight_reg})
                       < (fifo_cnt_w + 1)'(fifo_depth)) || pop);

  assign rsp_rdata = rsp_valid ? head.rdata[dbits-1:0] : '0;
  assign rsp_err   = rsp_valid && head.err;

  assign ram_addr  = req_addr[abits+lsb-1:lsb];
  assign ram_wdata = req_wdata;
  assign ram_we    = (accept && !req_err) ? req_we : '0;

  // Address bits outside the word index are deliberately ignored when not range-checked.
  assign unused_bits = ^{req_addr, head};

  axo_bram_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_axo_bram_port.sv
// Self-checking bench for axo_bram_port: behavioral read-first RAM plus a response scoreboard.
// Build with AXO_BRAM_RANGE_CHECK_EN defined to also exercise the address range check.
module tb_axo_bram_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_rsp;
  logic [31:0] ram_mem   [256];
  logic [31:0] model_mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  axo_bram_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port read-first RAM with one cycle of read latency.
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  // Scoreboard: compare responses as they are popped, then record newly accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
        end else begin
          exp_rsp = sb.pop_front();
          if (rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            n_fail++;
            $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                     rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
          end else begin
            $display("rsp rdata=%h err=%b", rsp_rdata, rsp_err);
          end
        end
      end
      if (req_valid && req_ready) begin
        logic        e;
        logic [7:0]  w;
        exp_t        x;
`ifdef AXO_BRAM_RANGE_CHECK_EN
        e = (req_addr[31:10] != 22'd0) || (req_addr[1:0] != 2'd0);
`else
        e = 1'b0;
`endif
        w       = req_addr[9:2];
        x.err   = e;
        x.rdata = e ? 32'h0 : model_mem[w];
        sb.push_back(x);
        if (!e) begin
          for (int b = 0; b < 4; b++) begin
            if (req_we[b]) model_mem[w][b*8 +: 8] = req_wdata[b*8 +: 8];
          end
        end
        $display("req addr=%h we=%h wdata=%h err=%b", req_addr, req_we, req_wdata, e);
      end
    end
  end

  // Called at posedge+1; holds the request until accepted, returns aligned to posedge+1.
  task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       output int waits);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = w;
    req_wdata = d;
    waits     = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_timeout: got req_ready=0 for %0d cycles, required acceptance", waits);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 4'h0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !rsp_valid) break;
    end
    n_checks++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending rsp_valid=%b, required 0 pending", sb.size(), rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_we    = 4'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, ram_we} !== 7'b0 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b we=%h rdata=%h, required all 0",
               req_ready, rsp_valid, rsp_err, ram_we, rsp_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int wt;
    rsp_ready = 1'b1;
    issue(32'h10, 4'hF, 32'hDEADBEEF, wt);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_old_word: got valid=%b rdata=%h, required valid=1 rdata=00000000", rsp_valid, rsp_rdata);
    end
    issue(32'h10, 4'h0, 32'h0, wt);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_new_word: got valid=%b rdata=%h, required valid=1 rdata=deadbeef", rsp_valid, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int wt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(32'h80 + 32'(i * 4), 4'hF, 32'h5A000000 + 32'(i), wt);
    drain();
    for (int i = 0; i < 8; i++) begin
      issue(32'h80 + 32'(i * 4), 4'h0, 32'h0, wt);
      n_checks++;
      if (wt != 0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A000000 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got waits=%0d valid=%b rdata=%h, required waits=0 valid=1 rdata=%h",
                 i, wt, rsp_valid, rsp_rdata, 32'h5A000000 + 32'(i));
      end
    end
    drain();
  endtask

  task automatic test_stall();
    int wt;
    rsp_ready = 1'b1;
    issue(32'h40, 4'hF, 32'hA1A1A1A1, wt);
    issue(32'h44, 4'hF, 32'hB2B2B2B2, wt);
    issue(32'h48, 4'hF, 32'hC3C3C3C3, wt);
    drain();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 4'h0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'h40 + 32'(i * 4);
      @(negedge clk);
      n_checks++;
      if (req_ready !== (i < 2)) begin
        n_fail++;
        $display("FAIL stall_ready_%0d: got %b, required %b", i, req_ready, (i < 2));
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hA1A1A1A1) begin
        n_fail++;
        $display("FAIL stall_hold: got ready=%b valid=%b rdata=%h, required ready=0 valid=1 rdata=a1a1a1a1",
                 req_ready, rsp_valid, rsp_rdata);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got ready=%b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_byte_we();
    int wt;
    rsp_ready = 1'b1;
    issue(32'h20, 4'hF, 32'h11223344, wt);
    issue(32'h20, 4'h2, 32'h0000AB00, wt);
    issue(32'h20, 4'h0, 32'h0, wt);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122AB44) begin
      n_fail++;
      $display("FAIL byte_we: got valid=%b rdata=%h, required valid=1 rdata=1122ab44", rsp_valid, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_reset_flush();
    int wt;
    rsp_ready = 1'b0;
    issue(32'h10, 4'h0, 32'h0, wt);
    issue(32'h20, 4'h0, 32'h0, wt);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_reset: got valid=%b ready=%b, required 0 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_rsp_%0d: got valid=%b rdata=%h, required valid=0", i, rsp_valid, rsp_rdata);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef AXO_BRAM_RANGE_CHECK_EN
  task automatic test_range();
    int wt;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h00000402;
    req_we    = 4'hF;
    req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || ram_we !== 4'h0) begin
      n_fail++;
      $display("FAIL range_we: got ready=%b ram_we=%h, required ready=1 ram_we=0", req_ready, ram_we);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 4'h0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL range_rsp: got valid=%b err=%b rdata=%h, required 1 1 00000000",
               rsp_valid, rsp_err, rsp_rdata);
    end
    issue(32'h00000000, 4'h0, 32'h0, wt);
    drain();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = 32'h0;
      model_mem[i] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_byte_we();
    test_reset_flush();
`ifdef AXO_BRAM_RANGE_CHECK_EN
    test_range();
`endif
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axo_bram_port.md
AXO_BRAM_PORT -- requirements
Module: axo_bram_port

Interface
REQ-001 SHALL have parameter abits, default 8: RAM word-address bits.
REQ-002 SHALL have parameter dbytes, default 4: data bytes per word.
REQ-003 SHALL have parameter blen, default 8: bits per byte.
REQ-004 SHALL have parameter pabits, default 32: request byte-address bits; dbits = dbytes*blen, local.
REQ-005 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have ports req_valid/req_ready, input/output, 1 each: request handshake.
REQ-008 SHALL have ports req_addr (pabits, byte address), req_we (dbytes, per-byte write enable) and req_wdata (dbits), all inputs: request payload.
REQ-009 SHALL have ports rsp_valid/rsp_ready, output/input, 1 each: response handshake.
REQ-010 SHALL have ports rsp_rdata (dbits) and rsp_err (1), both outputs: response payload.
REQ-011 SHALL have ports ram_we (dbytes), ram_addr (abits) and ram_wdata (dbits), outputs; ram_rdata (dbits), input: single-port, read-first, 1-cycle-latency RAM.

Function
REQ-012 SHALL accept a request on cycle N iff req_valid && req_ready ("accept").
REQ-013 SHALL drive ram_addr = req_addr[abits+log2(dbytes)-1 : log2(dbytes)], ram_wdata = req_wdata and ram_we = req_we only when accepting; otherwise ram_we = 0.
REQ-014 SHALL capture ram_rdata on cycle N+1 into a 2-entry response FIFO; the earliest rsp_valid for an accepted request is N+1.
REQ-015 SHALL return exactly one response per accepted request, in order; a write returns the pre-write word (read-first).
REQ-016 SHALL compute req_ready = (fifo_cnt + inflight < 2) || (rsp_valid && rsp_ready), combinationally.
REQ-017 SHALL never overflow the FIFO; fifo_cnt' = fifo_cnt + inflight - pop, and fifo_cnt' + inflight' <= 2 holds every cycle.
REQ-018 SHALL sustain one request per cycle while rsp_ready is held 1.
REQ-019 SHALL hold rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
REQ-020 SHALL, on a simultaneous push and pop with the FIFO full, pop the head and push the tail in the same cycle.

Reset
REQ-021 SHALL, on rst_n = 0 at a clock edge, clear inflight and fifo_cnt and drop any in-flight or buffered response.
REQ-022 SHALL hold req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0 and ram_we = 0 while rst_n = 0.

Configuration
REQ-023 SHALL, with AXO_BRAM_RANGE_CHECK_EN defined, flag a request as erroneous when req_addr has nonzero bits above the word index or nonzero low log2(dbytes) bits.
REQ-024 SHALL, for an erroneous request under AXO_BRAM_RANGE_CHECK_EN, force ram_we = 0, respond in order with rsp_err = 1 and rsp_rdata = 0, and keep the same latency.
REQ-025 SHALL, without AXO_BRAM_RANGE_CHECK_EN, ignore upper and low address bits (aliasing) and tie rsp_err to 0.

Structure
REQ-026 SHALL place the response-entry typedef (rdata, err) and the fifo-depth constant (2) in package axo_bram_pkg.
REQ-027 SHALL implement the FIFO as sub-module axo_bram_rsp_fifo: 2 entries, push/pop, count output.

Verification
REQ-028 SHALL cover: write addr 0x10, we=0xF, data 0xDEADBEEF, then read 0x10 -> first response 0x00000000 (old), second response 0xDEADBEEF, each 1 cycle after accept.
REQ-029 SHALL cover: 8 back-to-back reads with rsp_ready=1 -> req_ready stays 1 and 8 in-order responses arrive on consecutive cycles.
REQ-030 SHALL cover: rsp_ready=0 while 3 reads are offered -> 2 accepted, req_ready=0 until the first pop, and responses unchanged while stalled.
REQ-031 SHALL cover: write with we=0x2, data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-032 SHALL cover: rst_n=0 asserted with 2 buffered responses -> rsp_valid=0 the next cycle and no stale response after rst_n=1.
REQ-033 SHALL cover, with AXO_BRAM_RANGE_CHECK_EN: read 0x00000402 (abits=8) -> rsp_err=1, rdata=0, and ram_we never asserted.
